// File: rtl/module_mult_booth_seq.sv
//------------------------------------------------------------------------------
// module_mult_booth_seq
// Self-timed sequential radix-2 Booth multiplier with valid/ready handshakes.
// Optional MULT_BOOTH_UNSIGNED_EN adds the is_signed port for unsigned operands.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module module_mult_booth_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
`ifdef MULT_BOOTH_UNSIGNED_EN
    input  logic           is_signed,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Y,
    output logic           busy,
    output logic [1:0]     Q_LSB
);

    localparam int W  = N + 1;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    hq;
    logic [W-1:0]    lq;
    logic [W-1:0]    mreg;
    logic            q_1;
    logic [CW-1:0]   cnt;
    logic            ext_sign;
    logic            accept;
    logic            last_step;
    logic [W-1:0]    sum;
    logic [2*W-1:0]  shifted;

`ifdef MULT_BOOTH_UNSIGNED_EN
    assign ext_sign = is_signed;
`else
    assign ext_sign = 1'b1;
`endif

    assign accept    = in_valid && in_ready;
    assign last_step = (state == S_CALC) && (cnt == CNT_ONE);
    assign Q_LSB     = {lq[0], q_1};

    always_comb begin
        sum = hq;
        case ({lq[0], q_1})
            2'b01:   sum = hq + mreg;
            2'b10:   sum = hq - mreg;
            default: sum = hq;
        endcase
    end

    // Arithmetic right shift of {HQ,LQ,Q_1}; the bit falling out of LQ becomes Q_1.
    assign shifted = {sum[W-1], sum, lq[W-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = rst;
                if (accept) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hq   <= '0;
            lq   <= '0;
            mreg <= '0;
            q_1  <= 1'b0;
            cnt  <= '0;
            Y    <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                mreg <= {A[N-1] & ext_sign, A};
                lq   <= {B[N-1] & ext_sign, B};
                hq   <= '0;
                q_1  <= 1'b0;
                cnt  <= CNT_INIT;
            end
        end else if (state == S_CALC) begin
            hq  <= shifted[2*W-1:W];
            lq  <= shifted[W-1:0];
            q_1 <= lq[0];
            cnt <= cnt - CNT_ONE;
            if (last_step) begin
                Y <= shifted[2*N-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/module_mult_booth_seq.md
# module_mult_booth_seq

Self-timed sequential radix-2 Booth multiplier. It is the parametrised successor to the externally sequenced Booth datapath. The add/subtract/shift control FSM is internal, so the block needs no external control bus. Operands enter and products leave through valid/ready handshakes, and the block optionally supports signed or unsigned operands. It sits between the operand-capture logic and the result/display path of the arithmetic subsystem.

## Interface
- N, 8, operand width in bits; legal values N ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on A/B is valid.
- in_ready  output  1  block can accept operands.
- A  input  N  multiplicand.
- B  input  N  multiplier.
- is_signed  input  1  1 means A/B are two's complement, 0 means unsigned. Present only with MULT_BOOTH_UNSIGNED_EN.
- out_valid  output  1  Y holds a completed product.
- out_ready  input  1  consumer accepts Y.
- Y  output  2N  product.
- busy  output  1  FSM not in IDLE.
- Q_LSB  output  2  current Booth pair {Q0, Q_1}; debug and verification visibility.

## Operation
- Internal width: W = N+1. Each operand is extended by one bit at capture: sign-extended if signed, zero-extended if unsigned. Internal registers are HQ[W], LQ[W], Q_1, Mreg[W] and cnt[$clog2(W+1)].
- FSM states:
  - IDLE
    - in_ready=1.
    - On the in_valid && in_ready edge: Mreg←ext(A), LQ←ext(B), HQ←0, Q_1←0, cnt←W; go to CALC.
  - CALC, one step per cycle, selected by {LQ[0],Q_1}:
    - 01: HQ←HQ+Mreg.
    - 10: HQ←HQ−Mreg.
    - 00/11: no change.
    - Then arithmetic shift right of {HQ,LQ,Q_1} by 1.
    - cnt decrements each step.
    - When cnt reaches 1 at the edge, this is the last step: write Y←low 2N bits of {HQ,LQ} after the shift, and go to DONE.
  - DONE
    - out_valid=1.
    - On the out_valid && out_ready edge: go to IDLE.
- Add/subtract is W bits wide, modulo 2^W; overflow is discarded. The low 2N bits of the 2W product are exact for signed N×N and unsigned N×N.
- Y holds its value until the next completion. It is not cleared on handshake.
- in_ready=0 in CALC and DONE: no overlap, one operation in flight.
- Q_LSB = {LQ[0], Q_1} combinationally in every state.

## Timing
- Reset values: in_ready=0 while rst=0, then 1 from the first cycle after release. out_valid=0, Y=0, busy=0, Q_LSB=00, FSM=IDLE.
- Latency:
  - Operands accepted at edge t.
  - out_valid rises after edge t+W = t+N+1.
  - Y is valid in the same cycle out_valid rises.
- Backpressure: while out_valid=1 and out_ready=0, Y and out_valid hold indefinitely.
- in_ready returns to 1 the cycle after the output handshake edge.
- Minimum initiation interval with out_ready tied high: N+3 cycles.
- Operands are sampled only on the accepting edge. A/B changes during CALC have no effect.
- in_valid while in_ready=0 is ignored. Operands are not queued.
- Reset mid-operation (rst low in CALC or DONE): immediately out_valid=0, Y=0, busy=0, FSM=IDLE. The partial result is discarded.
- out_ready while out_valid=0 is ignored.

## Configuration
- MULT_BOOTH_UNSIGNED_EN defined:
  - is_signed port exists.
  - is_signed is sampled on the accepting edge and selects sign or zero extension.
- MULT_BOOTH_UNSIGNED_EN undefined:
  - is_signed port is absent.
  - Operands are always sign-extended (two's complement only).
  - Cycle timing is identical in both builds.

## Test plan
- N=8, signed, A=0x0B, B=0x0E, out_ready=1 → out_valid rises 9 cycles after accept; Y=0x009A.
- N=8, signed, A=0xFD (−3), B=0x05 → Y=0xFFF1. Then A=0x80, B=0x80 → Y=0x4000.
- N=8, MULT_BOOTH_UNSIGNED_EN, is_signed=0, A=0xFF, B=0xFF → Y=0xFE01. Same operands with is_signed=1 → Y=0x0001.
- Backpressure: A=0x07, B=0x06; hold out_ready=0 for 5 cycles after out_valid → Y=0x002A stable, out_valid high, in_ready=0; release → in_ready=1 next cycle.
- Reset mid-CALC: accept A=0x11, B=0x22; pull rst low 4 cycles later → out_valid=0, Y=0 immediately. After release, A=0x02, B=0x03 → Y=0x0006.
- N=16 random signed/unsigned regression (≥1000 operand pairs) against a reference model → all match. Latency is always 17 cycles.
